bist_resp_checker: RTL and testbench
====================================

Name: bist_resp_checker

Overview:
Read-side response analyzer for the memory BIST. The Bist controller and its data generator write patterns and issue read-backs. This block receives each returned read word together with its expected value, compares them, and compacts the stream into a MISR signature. It also logs the first failure and an error count, and reports the final pass/fail status and done to the test controller or top level.

Parameters:
ADR_SIZE, 4, width of read address.
DATA_SIZE, 8, width of data words, expected words and signature.
CNT_SIZE, 8, width of the saturating error counter.
MISR_POLY, 8'h1D, MISR feedback taps (DATA_SIZE bits).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle pulse; clears all results and begins a new check session.
rd_valid  in  1  read word present this cycle.
rd_adr  in  ADR_SIZE  address of the returned word.
rd_data  in  DATA_SIZE  data read from the memory under test.
exp_data  in  DATA_SIZE  expected data from the data generator.
rd_last  in  1  qualified by rd_valid; marks the final read of the session.
status  out  1  sticky fail flag: 1 means at least one mismatch.
done  out  1  level-high when the session is complete; held until start or rst.
err_count  out  CNT_SIZE  number of mismatching reads, saturating.
fail_adr  out  ADR_SIZE  address of the first mismatch.
fail_syn  out  DATA_SIZE  rd_data XOR exp_data at the first mismatch.
signature  out  DATA_SIZE  MISR over all rd_data accepted in the session.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Ports are named clk and rst.
- On rst, every output is 0, the FSM goes to IDLE and the pipeline valid bit is cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start -> RUN.
  - RUN: accepted rd_valid with rd_last -> DONE, one edge after the compare stage.
  - DONE: start -> RUN.
- start in any state clears status, done, err_count, fail_adr, fail_syn, signature and the pipeline valid bit, then enters RUN. Start in RUN restarts the session.
- start has priority over rd_valid in the same cycle; that read is dropped.
- rd_valid is accepted only in RUN. In IDLE and DONE it is ignored and nothing changes.
- Stage 1: at edge E an accepted read registers adr, data, exp and last. The signature also updates at edge E.
- Stage 2: at edge E+1 the compare result from the stage 1 registers is applied:
  - On mismatch, err_count increments, saturating at 2^CNT_SIZE-1, and status is set.
  - fail_adr and fail_syn load only when the mismatch is the first of the session (status still 0).
  - If last, done goes to 1 and the FSM enters DONE.
- Latency from the rd_valid cycle to a visible status/err_count/done update is 2 edges.
- Back-to-back rd_valid every cycle is supported with no stalls. There is no ready output.
- MISR update: sig_next = ((sig << 1) truncated to DATA_SIZE) ^ (sig[MSB] ? MISR_POLY : 0) ^ rd_data.
- Reads with rd_valid=1 but rd_last=0 after done are impossible, because the FSM has left RUN and they are ignored.
- Reset mid-session aborts the session immediately. All outputs return to 0.

Decomposition:
- Shared package bist_pkg holds:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default ADR_SIZE and DATA_SIZE;
  - the default MISR_POLY constant.
- One sub-module: bist_misr (DATA_SIZE, MISR_POLY; ports clk, rst, clr, en, din, sig). It is reusable on the controller side.

Test Plan:
- Reset: rst=1 for 10 cycles, then 0 -> all outputs 0, done=0. rd_valid pulses with no start -> still all 0.
- Clean pass: start, then 16 reads adr 0..15 with rd_data=exp_data=8'hAA and rd_last on adr 15 -> done=1 exactly 2 edges after the last read, status=0, err_count=0.
- Single fault: same as the clean pass but adr 5 returns 8'hFF against exp 8'hAA -> status=1, err_count=1, fail_adr=5, fail_syn=8'h55.
- Multiple faults and first-fail hold: mismatches at adr 3 and 9 -> err_count=2, fail_adr=3. With CNT_SIZE=2 and 5 mismatches -> err_count=3 (saturated).
- Signature: start, then read 8'hFF followed by 8'h00 -> signature 8'hFF after the first read, 8'hE3 after the second.
- Restart and priority: start asserted in RUN in the same cycle as a mismatching rd_valid -> all results 0 and the read is dropped. start during DONE -> done drops to 0 on the next edge.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the memory BIST read-side response checker.
package bist_pkg;

    localparam int unsigned BIST_ADR_SIZE  = 4;
    localparam int unsigned BIST_DATA_SIZE = 8;
    localparam int unsigned BIST_CNT_SIZE  = 8;

    localparam logic [BIST_DATA_SIZE-1:0] BIST_MISR_POLY = 8'h1D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_e;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register; compacts one data word per enabled cycle.
module bist_misr
    import bist_pkg::*;
#(
    parameter int unsigned             DATA_SIZE = BIST_DATA_SIZE,
    parameter logic [DATA_SIZE-1:0]    MISR_POLY = DATA_SIZE'(BIST_MISR_POLY)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DATA_SIZE-1:0] din,
    output logic [DATA_SIZE-1:0] sig
);

    logic [DATA_SIZE-1:0] r_sig;
    logic [DATA_SIZE-1:0] w_fb;

    assign w_fb = r_sig[DATA_SIZE-1] ? MISR_POLY : '0;

    // Shift with polynomial feedback and fold in the new word; clr starts a fresh signature.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= {r_sig[DATA_SIZE-2:0], 1'b0} ^ w_fb ^ din;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/bist_resp_checker.sv
// Compares returned read words against expected data, logs the first failure,
// counts mismatches and compacts the read stream into a MISR signature.
module bist_resp_checker
    import bist_pkg::*;
#(
    parameter int unsigned          ADR_SIZE  = BIST_ADR_SIZE,
    parameter int unsigned          DATA_SIZE = BIST_DATA_SIZE,
    parameter int unsigned          CNT_SIZE  = BIST_CNT_SIZE,
    parameter logic [DATA_SIZE-1:0] MISR_POLY = DATA_SIZE'(BIST_MISR_POLY)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 rd_valid,
    input  logic [ADR_SIZE-1:0]  rd_adr,
    input  logic [DATA_SIZE-1:0] rd_data,
    input  logic [DATA_SIZE-1:0] exp_data,
    input  logic                 rd_last,
    output logic                 status,
    output logic                 done,
    output logic [CNT_SIZE-1:0]  err_count,
    output logic [ADR_SIZE-1:0]  fail_adr,
    output logic [DATA_SIZE-1:0] fail_syn,
    output logic [DATA_SIZE-1:0] signature
);

    bist_state_e          r_state;
    logic                 r_s1_vld;
    logic                 r_s1_last;
    logic [ADR_SIZE-1:0]  r_s1_adr;
    logic [DATA_SIZE-1:0] r_s1_data;
    logic [DATA_SIZE-1:0] r_s1_exp;
    logic                 r_status;
    logic                 r_done;
    logic [CNT_SIZE-1:0]  r_err_count;
    logic [ADR_SIZE-1:0]  r_fail_adr;
    logic [DATA_SIZE-1:0] r_fail_syn;

    logic                 w_accept;
    logic                 w_mismatch;
    logic                 w_last_inflight;

    // The session ends at rd_last, so nothing is accepted while that read is still in stage 1.
    assign w_last_inflight = r_s1_vld && r_s1_last;
    assign w_accept        = rd_valid && (r_state == RUN) && !start && !w_last_inflight;
    assign w_mismatch      = r_s1_vld && (r_s1_data != r_s1_exp);

    // Stage 1: capture an accepted read.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_adr  <= '0;
            r_s1_data <= '0;
            r_s1_exp  <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_last <= rd_last;
                r_s1_adr  <= rd_adr;
                r_s1_data <= rd_data;
                r_s1_exp  <= exp_data;
            end
        end
    end

    // Session FSM with stage 2 result logging.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_status    <= 1'b0;
            r_done      <= 1'b0;
            r_err_count <= '0;
            r_fail_adr  <= '0;
            r_fail_syn  <= '0;
        end else if (start) begin
            r_state     <= RUN;
            r_status    <= 1'b0;
            r_done      <= 1'b0;
            r_err_count <= '0;
            r_fail_adr  <= '0;
            r_fail_syn  <= '0;
        end else begin
            case (r_state)
                IDLE: r_state <= IDLE;
                RUN: begin
                    if (w_mismatch) begin
                        r_status <= 1'b1;
                        if (!(&r_err_count)) begin
                            r_err_count <= r_err_count + CNT_SIZE'(1);
                        end
                        if (!r_status) begin
                            r_fail_adr <= r_s1_adr;
                            r_fail_syn <= r_s1_data ^ r_s1_exp;
                        end
                    end
                    if (w_last_inflight) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Signature over every accepted read word.
    bist_misr #(
        .DATA_SIZE (DATA_SIZE),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (w_accept),
        .din (rd_data),
        .sig (signature)
    );

    assign status    = r_status;
    assign done      = r_done;
    assign err_count = r_err_count;
    assign fail_adr  = r_fail_adr;
    assign fail_syn  = r_fail_syn;

endmodule

// File: tb/tb_bist_resp_checker.sv
// Scoreboard bench for bist_resp_checker (default counter width plus a 2-bit counter copy).
module tb_bist_resp_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rd_valid = 1'b0;
    logic [3:0] rd_adr = '0;
    logic [7:0] rd_data = '0;
    logic [7:0] exp_data = '0;
    logic       rd_last = 1'b0;

    logic       status, done;
    logic [7:0] err_count;
    logic [3:0] fail_adr;
    logic [7:0] fail_syn, signature;

    logic       status_2, done_2;
    logic [1:0] err_count_2;
    logic [3:0] fail_adr_2;
    logic [7:0] fail_syn_2, signature_2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bist_resp_checker u_dut (
        .clk (clk), .rst (rst), .start (start), .rd_valid (rd_valid),
        .rd_adr (rd_adr), .rd_data (rd_data), .exp_data (exp_data), .rd_last (rd_last),
        .status (status), .done (done), .err_count (err_count),
        .fail_adr (fail_adr), .fail_syn (fail_syn), .signature (signature)
    );

    bist_resp_checker #(.CNT_SIZE (2)) u_dut_c2 (
        .clk (clk), .rst (rst), .start (start), .rd_valid (rd_valid),
        .rd_adr (rd_adr), .rd_data (rd_data), .exp_data (exp_data), .rd_last (rd_last),
        .status (status_2), .done (done_2), .err_count (err_count_2),
        .fail_adr (fail_adr_2), .fail_syn (fail_syn_2), .signature (signature_2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [7:0] sig;
    } sig_e_t;

    typedef struct {
        int         due;
        logic       status;
        logic       done;
        logic [7:0] err;
        logic [1:0] err2;
        logic [3:0] fadr;
        logic [7:0] fsyn;
    } res_e_t;

    sig_e_t q_sig[$];
    res_e_t q_res[$];

    // Reference session state
    logic       m_run, m_status, m_done;
    logic [7:0] m_err, m_fsyn, m_sig;
    logic [1:0] m_err2;
    logic [3:0] m_fadr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
        logic [7:0] shl;
        shl = {s[6:0], 1'b0};
        return shl ^ (s[7] ? 8'h1D : 8'h00) ^ d;
    endfunction

    task automatic model_clear();
        m_status = 1'b0; m_done = 1'b0; m_err = '0; m_err2 = '0;
        m_fadr = '0; m_fsyn = '0; m_sig = '0;
    endtask

    task automatic push_sig(input int due);
        sig_e_t e;
        e.due = due; e.sig = m_sig;
        q_sig.push_back(e);
    endtask

    task automatic push_res(input int due);
        res_e_t e;
        e.due = due; e.status = m_status; e.done = m_done; e.err = m_err;
        e.err2 = m_err2; e.fadr = m_fadr; e.fsyn = m_fsyn;
        q_res.push_back(e);
    endtask

    task automatic purge_from(input int due_min);
        sig_e_t ts[$];
        res_e_t tr[$];
        foreach (q_sig[i]) if (q_sig[i].due < due_min) ts.push_back(q_sig[i]);
        foreach (q_res[i]) if (q_res[i].due < due_min) tr.push_back(q_res[i]);
        q_sig = ts;
        q_res = tr;
    endtask

    // One cycle of stimulus; expectations are queued for the edges they should appear on.
    task automatic drive(input logic st, input logic vld, input logic [3:0] adr,
                         input logic [7:0] d, input logic [7:0] e, input logic last);
        @(negedge clk);
        start = st; rd_valid = vld; rd_adr = adr; rd_data = d; exp_data = e; rd_last = last;
        if (st) begin
            model_clear();
            m_run = 1'b1;
            purge_from(cyc + 1);
            push_sig(cyc + 1);
            push_res(cyc + 1);
        end else if (vld && m_run) begin
            m_sig = misr_step(m_sig, d);
            push_sig(cyc + 1);
            if (d != e) begin
                if (!m_status) begin
                    m_fadr = adr;
                    m_fsyn = d ^ e;
                end
                m_status = 1'b1;
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
                if (m_err2 != 2'd3) m_err2 = m_err2 + 2'd1;
            end
            if (last) begin
                m_done = 1'b1;
                m_run  = 1'b0;
            end
            push_res(cyc + 2);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst = 1'b1; start = 1'b0; rd_valid = 1'b0; rd_last = 1'b0;
        model_clear();
        m_run = 1'b0;
        q_sig.delete();
        q_res.delete();
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".status"},    32'(status),      32'(m_status));
        chk({tag, ".done"},      32'(done),        32'(m_done));
        chk({tag, ".err_count"}, 32'(err_count),   32'(m_err));
        chk({tag, ".err_c2"},    32'(err_count_2), 32'(m_err2));
        chk({tag, ".fail_adr"},  32'(fail_adr),    32'(m_fadr));
        chk({tag, ".fail_syn"},  32'(fail_syn),    32'(m_fsyn));
        chk({tag, ".signature"}, 32'(signature),   32'(m_sig));
    endtask

    // 16-read session over adr 0..15; masked addresses return bad instead of 8'hAA.
    task automatic session(input logic [15:0] fault_mask, input logic [7:0] bad);
        drive(1'b1, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'(i), fault_mask[i] ? bad : 8'hAA, 8'hAA, i == 15);
        end
        idle(3);
    endtask

    // Compare DUT outputs against queued expectations on the falling edge.
    always @(negedge clk) begin
        while (q_sig.size() > 0 && q_sig[0].due == cyc) begin
            sig_e_t e;
            e = q_sig.pop_front();
            chk("sb.signature", 32'(signature), 32'(e.sig));
        end
        while (q_res.size() > 0 && q_res[0].due == cyc) begin
            res_e_t e;
            e = q_res.pop_front();
            chk("sb.status",    32'(status),      32'(e.status));
            chk("sb.done",      32'(done),        32'(e.done));
            chk("sb.err_count", 32'(err_count),   32'(e.err));
            chk("sb.err_c2",    32'(err_count_2), 32'(e.err2));
            chk("sb.fail_adr",  32'(fail_adr),    32'(e.fadr));
            chk("sb.fail_syn",  32'(fail_syn),    32'(e.fsyn));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        model_clear();
        m_run = 1'b0;

        // Reset, then reads without start are ignored
        apply_reset(10);
        check_all("reset");
        drive(1'b0, 1'b1, 4'd2, 8'h12, 8'h34, 1'b0);
        drive(1'b0, 1'b1, 4'd3, 8'h56, 8'h78, 1'b1);
        idle(3);
        check_all("idle_reads");
        chk("idle_reads.sig_zero", 32'(signature), 32'h0);

        // Clean pass
        session(16'h0000, 8'hAA);
        check_all("clean");
        chk("clean.done",   32'(done),      32'd1);
        chk("clean.status", 32'(status),    32'd0);
        chk("clean.err",    32'(err_count), 32'd0);

        // Reads after done are ignored
        drive(1'b0, 1'b1, 4'd7, 8'h00, 8'hAA, 1'b0);
        idle(3);
        check_all("after_done");

        // Single fault at adr 5
        session(16'h0020, 8'hFF);
        check_all("single");
        chk("single.fail_adr", 32'(fail_adr),  32'd5);
        chk("single.fail_syn", 32'(fail_syn),  32'h55);
        chk("single.err",      32'(err_count), 32'd1);

        // Faults at adr 3 and 9, first failure held
        session(16'h0208, 8'h2A);
        check_all("multi");
        chk("multi.err",      32'(err_count), 32'd2);
        chk("multi.fail_adr", 32'(fail_adr),  32'd3);
        chk("multi.fail_syn", 32'(fail_syn),  32'h80);

        // Five faults: 2-bit counter saturates
        session(16'h00F8, 8'h55);
        check_all("five");
        chk("five.err",    32'(err_count),   32'd5);
        chk("five.err_c2", 32'(err_count_2), 32'd3);

        // Signature of FF then 00
        drive(1'b1, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
        drive(1'b0, 1'b1, 4'd0, 8'hFF, 8'hFF, 1'b0);
        @(posedge clk); #1;
        chk("sig.first", 32'(signature), 32'hFF);
        drive(1'b0, 1'b1, 4'd1, 8'h00, 8'h00, 1'b1);
        @(posedge clk); #1;
        chk("sig.second", 32'(signature), 32'hE3);
        idle(3);
        check_all("sig");

        // Start in RUN together with a mismatching read: read is dropped
        drive(1'b1, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
        drive(1'b0, 1'b1, 4'd1, 8'h01, 8'hAA, 1'b0);
        drive(1'b0, 1'b1, 4'd2, 8'h02, 8'hAA, 1'b0);
        drive(1'b1, 1'b1, 4'd4, 8'h00, 8'hAA, 1'b0);
        idle(3);
        check_all("restart");
        chk("restart.err",    32'(err_count), 32'd0);
        chk("restart.status", 32'(status),    32'd0);
        chk("restart.sig",    32'(signature), 32'd0);
        drive(1'b0, 1'b1, 4'd6, 8'h3C, 8'h3C, 1'b1);
        idle(3);
        check_all("restart_end");
        chk("restart_end.done", 32'(done), 32'd1);

        // Start during DONE drops done on the next edge
        drive(1'b1, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
        @(posedge clk); #1;
        chk("done_drop", 32'(done), 32'd0);
        drive(1'b0, 1'b1, 4'd8, 8'h11, 8'h22, 1'b0);
        drive(1'b0, 1'b1, 4'd9, 8'h33, 8'h33, 1'b0);

        // Reset mid-session aborts everything
        apply_reset(2);
        idle(2);
        check_all("mid_reset");
        chk("mid_reset.status", 32'(status), 32'd0);

        idle(2);
        chk("queues_drained", 32'(q_sig.size() + q_res.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
